// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Requester indices, FSM state encoding and a one-hot to index helper.
// Imported by the arbiter top and its round-robin picker.
package mem_arb_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_DMA = 2'd0;
  localparam logic [1:0] REQ_CPU = 2'd1;
  localparam logic [1:0] REQ_ACL = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Convert a one-hot requester vector to its index (0 when empty)
  function automatic logic [1:0] oh_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_3.sv
// Combinational round-robin pick among three requesters.
// Latency: zero cycles; result is a pure function of request vector and pointer.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter_3
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_found
);

  logic [1:0] w_idx;

  // Scan upward from the pointer modulo 3; first asserted request wins
  always_comb begin
    o_gnt   = '0;
    o_found = 1'b0;
    w_idx   = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = 2'((32'(i_ptr) + 32'(k)) % NUM_REQ);
      if (!o_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory controller request port among DMA, CPU and accelerator.
// Latency: request in IDLE at N -> mem_en at N+1; mem_valid at M -> _valid at M+1.
// Backpressure: one transaction in flight; other requesters wait holding _en.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 28,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dma_en,
  input  logic                  dma_wr_en,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_data,
  output logic [DATA_WIDTH-1:0] dma_out,
  output logic                  dma_valid,
  input  logic                  cpu_en,
  input  logic                  cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  output logic [DATA_WIDTH-1:0] cpu_out,
  output logic                  cpu_valid,
  input  logic                  acl_en,
  input  logic                  acl_wr_en,
  input  logic [ADDR_WIDTH-1:0] acl_addr,
  input  logic [DATA_WIDTH-1:0] acl_data,
  output logic [DATA_WIDTH-1:0] acl_out,
  output logic                  acl_valid,
  input  logic                  dma_lock,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid,
  output logic [2:0]            grant,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                r_state, w_state_nxt;
  logic [NUM_REQ-1:0]    w_req, w_req_wr, w_pick, r_grant, r_valid;
  logic                  w_found, w_win, w_timeout, w_done;
  logic [1:0]            w_pick_idx, r_idx, r_ptr;
  logic                  r_mem_en, r_wr, r_busy, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] w_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];
  logic [DATA_WIDTH-1:0] r_out  [NUM_REQ];

  assign w_req    = {acl_en, cpu_en, dma_en};
  assign w_req_wr = {acl_wr_en, cpu_wr_en, dma_wr_en};
  assign w_addr[REQ_DMA] = dma_addr;
  assign w_addr[REQ_CPU] = cpu_addr;
  assign w_addr[REQ_ACL] = acl_addr;
  assign w_data[REQ_DMA] = dma_data;
  assign w_data[REQ_CPU] = cpu_data;
  assign w_data[REQ_ACL] = acl_data;

  rr_arbiter_3 u_rr (
    .i_req  (w_req),
    .i_ptr  (r_ptr),
    .o_gnt  (w_pick),
    .o_found(w_found)
  );

  assign w_pick_idx = oh_to_idx(w_pick);
  assign w_win      = (r_state == IDLE) && w_found;
  // A late mem_valid on the last allowed cycle still counts as a normal completion
  assign w_timeout  = (r_state == WAIT) && !mem_valid && (r_cnt == CNT_LAST);
  assign w_done     = (r_state == WAIT) && (mem_valid || w_timeout);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: IDLE waits for a pick, ISSUE lasts one cycle, WAIT ends on completion
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the winner's request and drive the registered memory-side strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= 2'd0;
      r_grant  <= '0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_mem_en <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_mem_en <= w_win;
      r_busy   <= (w_state_nxt != IDLE);
      if (w_win) begin
        r_idx   <= w_pick_idx;
        r_grant <= w_pick;
        r_wr    <= w_req_wr[w_pick_idx];
        r_addr  <= w_addr[w_pick_idx];
        r_wdata <= w_data[w_pick_idx];
      end else if (w_done) begin
        r_grant <= '0;
      end
    end
  end

  // Completion: pulse the winner's _valid, return data, advance the pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_ptr   <= 2'd0;
      for (int i = 0; i < NUM_REQ; i++) r_out[i] <= '0;
    end else begin
      r_valid <= '0;
      if (w_done) begin
        r_valid[r_idx] <= 1'b1;
        r_out[r_idx]   <= (mem_valid && !r_wr) ? mem_rdata : '0;
        if ((r_idx == REQ_DMA) && dma_lock) r_ptr <= REQ_DMA;
        else if (r_idx == REQ_ACL)          r_ptr <= REQ_DMA;
        else                                r_ptr <= r_idx + 2'd1;
      end
    end
  end

  // WAIT-cycle counter and sticky timeout flag (a timeout beats a same-cycle clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if ((r_state == WAIT) && !w_done) r_cnt <= r_cnt + CNT_W'(1);
      else                              r_cnt <= '0;
      if (w_timeout)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_wr_en = r_wr;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign grant     = r_grant;
  assign busy      = r_busy;
  assign err       = r_err;
  assign dma_valid = r_valid[REQ_DMA];
  assign cpu_valid = r_valid[REQ_CPU];
  assign acl_valid = r_valid[REQ_ACL];
  assign dma_out   = r_out[REQ_DMA];
  assign cpu_out   = r_out[REQ_CPU];
  assign acl_out   = r_out[REQ_ACL];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a short timeout.
// Inputs change and outputs are sampled 1ns after the rising edge.
// Each scenario task carries its own comparisons.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 28;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dma_en = 0, cpu_en = 0, acl_en = 0;
  logic          dma_wr_en = 0, cpu_wr_en = 0, acl_wr_en = 0;
  logic [AW-1:0] dma_addr = '0, cpu_addr = '0, acl_addr = '0;
  logic [DW-1:0] dma_data = '0, cpu_data = '0, acl_data = '0;
  logic [DW-1:0] dma_out, cpu_out, acl_out;
  logic          dma_valid, cpu_valid, acl_valid;
  logic          dma_lock = 0;
  logic          mem_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_valid = 0;
  logic [2:0]    grant;
  logic          busy, err;
  logic          err_clr = 0;

  int checks   = 0;
  int failures = 0;
  int vcnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .dma_en(dma_en), .dma_wr_en(dma_wr_en), .dma_addr(dma_addr), .dma_data(dma_data),
    .dma_out(dma_out), .dma_valid(dma_valid),
    .cpu_en(cpu_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_out(cpu_out), .cpu_valid(cpu_valid),
    .acl_en(acl_en), .acl_wr_en(acl_wr_en), .acl_addr(acl_addr), .acl_data(acl_data),
    .acl_out(acl_out), .acl_valid(acl_valid),
    .dma_lock(dma_lock),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .grant(grant), .busy(busy), .err(err), .err_clr(err_clr)
  );

  // Count every _valid cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (dma_valid) vcnt[0]++;
    if (cpu_valid) vcnt[1]++;
    if (acl_valid) vcnt[2]++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {dma_en, cpu_en, acl_en} = '0;
    {dma_wr_en, cpu_wr_en, acl_wr_en} = '0;
    dma_lock = 0; mem_valid = 0; err_clr = 0; mem_rdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Memory responder: wait for mem_en, answer in the first WAIT cycle
  task automatic serve(input logic lock_during, input logic [DW-1:0] rdata,
                       output logic [2:0] g, output logic [2:0] v, output logic ok);
    ok = 1'b0; g = '0; v = '0;
    for (int i = 0; i < 20; i++) begin
      if (mem_en) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      g = grant;
      dma_lock = lock_during;
      tick();
      mem_valid = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_valid = 1'b0;
      v = {acl_valid, cpu_valid, dma_valid};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({mem_en, mem_wr_en, mem_addr, mem_wdata, grant, busy, err} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got en=%b wr=%b addr=%h wdata=%h grant=%b busy=%b err=%b expected all 0",
               mem_en, mem_wr_en, mem_addr, mem_wdata, grant, busy, err);
    end
    checks++;
    if ({dma_valid, cpu_valid, acl_valid, dma_out, cpu_out, acl_out} !== '0) begin
      failures++;
      $display("FAIL reset_resp got valid=%b%b%b outs=%h/%h/%h expected all 0",
               dma_valid, cpu_valid, acl_valid, dma_out, cpu_out, acl_out);
    end
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_en = 1; cpu_wr_en = 0; cpu_addr = 28'h0000010;
    tick();
    checks++;
    if ({mem_en, mem_wr_en, mem_addr, grant, busy} !== {1'b1, 1'b0, 28'h0000010, 3'b010, 1'b1}) begin
      failures++;
      $display("FAIL cpu_issue got en=%b wr=%b addr=%h grant=%b busy=%b expected 1 0 0000010 010 1",
               mem_en, mem_wr_en, mem_addr, grant, busy);
    end
    tick();
    checks++;
    if ({mem_en, grant} !== {1'b0, 3'b010}) begin
      failures++;
      $display("FAIL cpu_wait got en=%b grant=%b expected 0 010", mem_en, grant);
    end
    tick();
    tick();
    mem_valid = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_valid = 0; cpu_en = 0;
    checks++;
    if ({cpu_valid, cpu_out, grant, busy} !== {1'b1, 32'hDEADBEEF, 3'b000, 1'b0}) begin
      failures++;
      $display("FAIL cpu_done got valid=%b out=%h grant=%b busy=%b expected 1 deadbeef 000 0",
               cpu_valid, cpu_out, grant, busy);
    end
    tick();
    checks++;
    if ({cpu_valid, mem_en} !== 2'b00) begin
      failures++;
      $display("FAIL cpu_pulse got valid=%b mem_en=%b expected 0 0", cpu_valid, mem_en);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] g, v, exp;
    logic ok;
    int base [3];
    do_reset();
    base = vcnt;
    {dma_en, cpu_en, acl_en} = 3'b111;
    for (int i = 0; i < 6; i++) begin
      serve(1'b0, 32'h100 + 32'(i), g, v, ok);
      if (i == 5) {dma_en, cpu_en, acl_en} = 3'b000;
      exp = 3'b001 << (i % 3);
      checks++;
      if (!ok || g !== exp || v !== exp) begin
        failures++;
        $display("FAIL rr_order[%0d] got ok=%b grant=%b valid=%b expected grant=valid=%b", i, ok, g, v, exp);
      end
    end
    tick();
    tick();
    checks++;
    if ((vcnt[0] - base[0]) != 2 || (vcnt[1] - base[1]) != 2 || (vcnt[2] - base[2]) != 2) begin
      failures++;
      $display("FAIL rr_pulses got %0d/%0d/%0d expected 2/2/2",
               vcnt[0] - base[0], vcnt[1] - base[1], vcnt[2] - base[2]);
    end
  endtask

  task automatic test_dma_lock();
    logic [2:0] g, v;
    logic ok;
    do_reset();
    dma_lock = 1;
    {dma_en, cpu_en, acl_en} = 3'b111;
    // Lock dropped during the fourth transaction, so its completion moves the pointer
    for (int i = 0; i < 4; i++) begin
      serve(i < 3, 32'h0, g, v, ok);
      checks++;
      if (!ok || g !== 3'b001) begin
        failures++;
        $display("FAIL lock_dma[%0d] got ok=%b grant=%b expected 001", i, ok, g);
      end
    end
    serve(1'b0, 32'h0, g, v, ok);
    {dma_en, cpu_en, acl_en} = 3'b000;
    checks++;
    if (!ok || g !== 3'b010) begin
      failures++;
      $display("FAIL unlock_next got ok=%b grant=%b expected 010", ok, g);
    end
    tick();
  endtask

  task automatic test_dma_write();
    do_reset();
    dma_en = 1; dma_wr_en = 1; dma_addr = 28'h0ABCDEF; dma_data = 32'h12345678;
    tick();
    checks++;
    if ({mem_en, mem_wr_en, mem_addr, mem_wdata, grant} !==
        {1'b1, 1'b1, 28'h0ABCDEF, 32'h12345678, 3'b001}) begin
      failures++;
      $display("FAIL dma_wr_issue got en=%b wr=%b addr=%h wdata=%h grant=%b expected 1 1 0abcdef 12345678 001",
               mem_en, mem_wr_en, mem_addr, mem_wdata, grant);
    end
    tick();
    mem_valid = 1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_valid = 0; dma_en = 0; dma_wr_en = 0;
    checks++;
    if ({dma_valid, dma_out} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL dma_wr_done got valid=%b out=%h expected 1 00000000", dma_valid, dma_out);
    end
    tick();
  endtask

  task automatic test_timeout();
    logic early, seen, ok;
    logic [2:0] g, v;
    do_reset();
    acl_en = 1; acl_wr_en = 0; acl_addr = 28'h0000200; mem_rdata = 32'hA5A5A5A5;
    tick();
    checks++;
    if (grant !== 3'b100) begin
      failures++;
      $display("FAIL to_grant got %b expected 100", grant);
    end
    early = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (acl_valid || !busy || err) early = 1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL to_early got early_end=%b expected 0", early);
    end
    tick();
    acl_en = 0;
    checks++;
    if ({acl_valid, acl_out, err, grant, busy} !== {1'b1, 32'h0, 1'b1, 3'b000, 1'b0}) begin
      failures++;
      $display("FAIL to_fire got valid=%b out=%h err=%b grant=%b busy=%b expected 1 00000000 1 000 0",
               acl_valid, acl_out, err, grant, busy);
    end
    tick();
    tick();
    checks++;
    if ({err, acl_valid} !== 2'b10) begin
      failures++;
      $display("FAIL to_sticky got err=%b valid=%b expected 1 0", err, acl_valid);
    end
    cpu_en = 1; cpu_wr_en = 0; cpu_addr = 28'h0000040;
    serve(1'b0, 32'h0BADF00D, g, v, ok);
    cpu_en = 0;
    checks++;
    if (!ok || g !== 3'b010 || cpu_out !== 32'h0BADF00D || err !== 1'b1) begin
      failures++;
      $display("FAIL to_recover got ok=%b grant=%b out=%h err=%b expected 1 010 0badf00d 1", ok, g, cpu_out, err);
    end
    err_clr = 1;
    tick();
    err_clr = 0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got %b expected 0", err);
    end
    // Timeout with clear held high: set must win on the timeout edge
    acl_en = 1; err_clr = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acl_valid) begin
        seen = 1;
        break;
      end
    end
    acl_en = 0;
    checks++;
    if ({seen, err} !== 2'b11) begin
      failures++;
      $display("FAIL err_set_wins got seen=%b err=%b expected 1 1", seen, err);
    end
    tick();
    err_clr = 0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear2 got %b expected 0", err);
    end
  endtask

  task automatic test_reset_in_wait();
    int base [3];
    do_reset();
    cpu_en = 1; cpu_addr = 28'h0000080;
    tick();
    tick();
    tick();
    base = vcnt;
    rst_n = 0; cpu_en = 0;
    #1;
    checks++;
    if ({mem_en, grant, busy, cpu_valid, cpu_out} !== '0) begin
      failures++;
      $display("FAIL rst_wait got en=%b grant=%b busy=%b valid=%b out=%h expected all 0",
               mem_en, grant, busy, cpu_valid, cpu_out);
    end
    tick();
    rst_n = 1;
    tick();
    mem_valid = 1; mem_rdata = 32'h55AA55AA;
    tick();
    mem_valid = 0;
    tick();
    checks++;
    if ({mem_en, grant, busy, dma_valid, cpu_valid, acl_valid, cpu_out} !== '0) begin
      failures++;
      $display("FAIL stale_valid got en=%b grant=%b busy=%b valid=%b%b%b out=%h expected all 0",
               mem_en, grant, busy, dma_valid, cpu_valid, acl_valid, cpu_out);
    end
    checks++;
    if (vcnt[0] != base[0] || vcnt[1] != base[1] || vcnt[2] != base[2]) begin
      failures++;
      $display("FAIL rst_no_pulse got %0d/%0d/%0d extra pulses expected 0/0/0",
               vcnt[0] - base[0], vcnt[1] - base[1], vcnt[2] - base[2]);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_dma_lock();
    test_dma_write();
    test_timeout();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
